clk_div_ctrl: RTL
=================

# clk_div_ctrl

Run-time programmable integer clock divider controller with glitch-free ratio changes. Software or an upstream sequencer programs a divide ratio through a valid/ready handshake. The block produces `clk_out` from `clk` and applies every ratio change, including start and stop, only at an output-period boundary, so no runt pulse is ever emitted. It sits between the clock-configuration register interface and the clock consumers of the divided domain.

## Interface
- `W`, default 4: ratio/counter width; legal ratios are 2..2^W-1.
- `clk`  in  1  source clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `cfg_vld`  in  1  new ratio request.
- `cfg_div`  in  W  requested ratio; 0 means stop, 1 is illegal.
- `cfg_rdy`  out  1  request may be accepted this cycle.
- `cfg_err`  out  1  one-cycle pulse flagging an illegal ratio.
- `clk_out`  out  1  divided clock, `pos_q | neg_q`.
- `div_cur`  out  W  ratio currently in effect; 0 when stopped.
- `period_start`  out  1  one-cycle pulse at each posedge that begins an output period.

## Operation
- Registers:
  - `state` ∈ {IDLE, RUN, DRAIN}.
  - `cnt_q` [W], `div_q` [W], `pend_q` [W].
  - `pos_q`, driven on posedge.
  - `neg_q`, driven on negedge.
- A handshake occurs when `cfg_vld && cfg_rdy` at a posedge. `cfg_rdy = (state != DRAIN)`.
- Illegal request (`cfg_div == 1`): accepted; `cfg_err` is 1 for the next cycle; `state`, `div_q` and `pend_q` are unchanged.
- Boundary edge: any posedge in IDLE, or a posedge in RUN/DRAIN with `cnt_q == div_q-1`.
- A legal request is applied at the first boundary edge at or after the handshake edge. If the handshake edge is itself a boundary, it applies there with no pending stage.
  - RUN, handshake not on a boundary: store `pend_q`, go to DRAIN.
  - DRAIN, at the boundary: load `div_q <= pend_q`, go to RUN; or go to IDLE if `pend_q == 0`.
- At every boundary edge in RUN with nothing pending: `cnt_q <= 0`, ratio kept. Otherwise `cnt_q <= cnt_q+1`.
- Applying a nonzero ratio N:
  - `cnt_q <= 0`, `div_q <= N`.
  - `pos_q` is set from the next count: `pos_q <= (cnt_next < N/2)`, using integer division.
- Applying ratio 0 (stop):
  - `div_q <= 0`, `cnt_q <= 0`, `pos_q <= 0`, state IDLE.
  - `neg_q` still falls naturally, so the last period completes.
- Requesting 0 while in IDLE is accepted and has no effect. Requesting the current ratio is accepted and restarts the period at the boundary, which is already the natural wrap, so it causes no disturbance.
- `neg_q` at each negedge: `neg_q <= pos_q & div_q[0]`. For even ratios `neg_q` is held 0.
- `period_start` is a registered pulse, high the cycle after any edge that loads `cnt_q <= 0` with `div_q != 0` after the update.
- `div_cur = div_q`.

## Timing
- Reset (asynchronous, active-low) clears everything immediately:
  - `state` = IDLE; `cnt_q`, `div_q`, `pend_q`, `pos_q`, `neg_q` = 0.
  - `clk_out` = 0, `cfg_rdy` = 1, `cfg_err` = 0, `period_start` = 0, `div_cur` = 0.
- Reset mid-high forces `clk_out` low without waiting for a clock edge.
- Start from IDLE: handshake at edge E with N. `clk_out` rises just after E; `div_cur` = N from E.
- Output waveform for ratio N:
  - Period is N clk cycles.
  - Even N: high for N/2 cycles.
  - Odd N: high for (N-1)/2 + 0.5 cycles (negedge extension).
- Change latency: the old period always completes. New ratio takes effect at most `div_q` cycles after the handshake.
- A `cfg_vld` request raised while `cfg_rdy` = 0 is held by the requester until accepted.
- `cfg_rdy` returns high the cycle after the DRAIN boundary.

## Configuration
- `CLK_DIV_CTRL_DUTY50_EN` defined: `neg_q` and the negedge flop are present; odd ratios have 50% duty.
- `CLK_DIV_CTRL_DUTY50_EN` undefined:
  - No negedge logic; `clk_out = pos_q`.
  - Odd N is high for (N-1)/2 cycles.
  - Even-ratio behaviour and all control timing are identical.

## Test plan
- Reset then idle for 10 cycles -> `clk_out` = 0, `cfg_rdy` = 1, `div_cur` = 0, no `period_start`.
- Program 4 from IDLE -> `clk_out` period 4 cycles, high 2; `period_start` every 4th cycle; `div_cur` = 4.
- Program 3 with DUTY50 -> high 1.5 and low 1.5 cycles. Without DUTY50 -> high 1 and low 2.
- In RUN at ratio 5, request 6 when `cnt_q` = 1 -> `cfg_rdy` low 3 cycles, 5-cycle period completes, then 6-cycle periods; no pulse shorter than 2 cycles.
- Request 1 while running at 4 -> `cfg_err` pulse 1 cycle, `div_cur` stays 4, waveform unchanged. Request 0 -> current period finishes, `clk_out` stays 0, `div_cur` = 0.
- Running at 7, assert `rst` mid-high phase -> `clk_out` low immediately. After release, everything at reset values until reprogrammed.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Programmable integer clock divider; ratio changes land only on output-period boundaries, cfg_rdy low while one waits.
// Define CLK_DIV_CTRL_DUTY50_EN to add the negedge flop that gives odd ratios 50% duty.
module clk_div_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_vld,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_rdy,
  output logic         cfg_err,
  output logic         clk_out,
  output logic [W-1:0] div_cur,
  output logic         period_start
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t         r_state, w_state_nxt;
  logic [W-1:0]   r_cnt, r_div, r_pend;
  logic [W-1:0]   w_cnt_nxt, w_div_nxt, w_pend_nxt;
  logic           r_pos, r_err, r_ps;
  logic           w_hs, w_legal, w_boundary, w_pos_nxt, w_clk_out;

  assign w_hs       = cfg_vld && cfg_rdy;
  assign w_legal    = w_hs && (cfg_div != W'(1));
  assign w_boundary = (r_state == IDLE) || (r_cnt == r_div - W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_pend  <= '0;
      r_pos   <= 1'b0;
      r_err   <= 1'b0;
      r_ps    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_div   <= w_div_nxt;
      r_pend  <= w_pend_nxt;
      r_pos   <= w_pos_nxt;
      r_err   <= w_hs && (cfg_div == W'(1));
      r_ps    <= (w_cnt_nxt == '0) && (w_div_nxt != '0);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + W'(1);
    w_div_nxt   = r_div;
    w_pend_nxt  = r_pend;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_legal && (cfg_div != '0)) begin
          w_div_nxt   = cfg_div;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          if (w_legal) begin
            w_div_nxt = cfg_div;
            if (cfg_div == '0) w_state_nxt = IDLE;
          end
        end else if (w_legal) begin
          // mid-period request: park it until the current period wraps
          w_pend_nxt  = cfg_div;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (w_boundary) begin
          w_cnt_nxt   = '0;
          w_div_nxt   = r_pend;
          w_state_nxt = (r_pend == '0) ? IDLE : RUN;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
    w_pos_nxt = (w_div_nxt != '0) && (w_cnt_nxt < (w_div_nxt >> 1));
  end

`ifdef CLK_DIV_CTRL_DUTY50_EN
  logic r_neg;

  // half-cycle extension of the high phase, only for odd ratios
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) r_neg <= 1'b0;
    else      r_neg <= r_pos & r_div[0];
  end

  assign w_clk_out = r_pos | r_neg;
`else
  assign w_clk_out = r_pos;
`endif

  always_comb begin
    cfg_rdy      = (r_state != DRAIN);
    cfg_err      = r_err;
    clk_out      = w_clk_out;
    div_cur      = r_div;
    period_start = r_ps;
  end

endmodule
